// File: rtl/mux_alt_pkg.sv
// mux_alt_pkg: shared widths, FIFO depth and one-hot FSM encoding for mux_alt.
// Contents: DATA_W, WORD_W ({sof, data}), FIFO_DEPTH, state_e, mk_word().
package mux_alt_pkg;

    localparam int DATA_W     = 8;
    localparam int WORD_W     = DATA_W + 1;
    localparam int FIFO_DEPTH = 4;

    typedef enum logic [5:0] {
        RESET       = 6'b000001,
        INICIAL     = 6'b000010,
        TRANS_0     = 6'b000100,
        TRANS_1     = 6'b001000,
        W_LST_DATA0 = 6'b010000,
        W_LST_DATA1 = 6'b100000
    } state_e;

    // FIFO word layout: start-of-burst flag in the MSB, data below it.
    function automatic logic [WORD_W-1:0] mk_word(input logic sof, input logic [DATA_W-1:0] data);
        return {sof, data};
    endfunction

endpackage

// File: rtl/mux_alt_fifo_mux.sv
// fifo_mux: 4-entry synchronous FIFO of {sof, data} words for one mux_alt lane.
// Ports: clk_i, rst_i (sync, active-high), push_i/din_i (write), pop_i (read),
//        head_o (current oldest word), empty_o, full_o, drop_o (write lost to a full FIFO).
module fifo_mux
    import mux_alt_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [WORD_W-1:0] din_i,
    input  logic              pop_i,
    output logic [WORD_W-1:0] head_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              drop_o
);

    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [1:0]        wr_ptr_q, rd_ptr_q;
    logic [2:0]        cnt_q, cnt_d;
    logic              do_push, do_pop;

    assign empty_o = (cnt_q == 3'd0);
    assign full_o  = (cnt_q == 3'(FIFO_DEPTH));
    assign head_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the write.
    assign do_push = push_i && (!full_o || do_pop);
    assign drop_o  = push_i && full_o && !do_pop;
    assign cnt_d   = cnt_q + {2'b00, do_push} - {2'b00, do_pop};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            cnt_q    <= 3'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + 2'd1;
            end
            if (do_pop)
                rd_ptr_q <= rd_ptr_q + 2'd1;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux_alt.sv
// mux_alt: merges two 8-bit lane streams into one, alternating whole bursts (lane 0 first).
// Ports: clk2f, reset (sync, active-high), data_in_x_c/valid_in_x_c (lane inputs),
//        data_out_c/valid_out_c (registered merged stream), ovf_0/ovf_1 (sticky drop flags).
// Build option: define MUX_ALT_OVF_EN to enable the overflow flags; otherwise they are tied 0.
module mux_alt
    import mux_alt_pkg::*;
(
    input  logic              clk2f,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in_0_c,
    input  logic              valid_in_0_c,
    input  logic [DATA_W-1:0] data_in_1_c,
    input  logic              valid_in_1_c,
    output logic [DATA_W-1:0] data_out_c,
    output logic              valid_out_c,
    output logic              ovf_0,
    output logic              ovf_1
);

    state_e            state_q, state_d;
    logic              prev_v0_q, prev_v1_q;
    logic [WORD_W-1:0] head0, head1;
    logic              empty0, empty1, full0, full1, drop0, drop1;
    logic              pop0, pop1;
    logic              start0, start1, more0, more1;

    fifo_mux u_fifo0 (
        .clk_i   (clk2f),
        .rst_i   (reset),
        .push_i  (valid_in_0_c),
        .din_i   (mk_word(!prev_v0_q, data_in_0_c)),
        .pop_i   (pop0),
        .head_o  (head0),
        .empty_o (empty0),
        .full_o  (full0),
        .drop_o  (drop0)
    );

    fifo_mux u_fifo1 (
        .clk_i   (clk2f),
        .rst_i   (reset),
        .push_i  (valid_in_1_c),
        .din_i   (mk_word(!prev_v1_q, data_in_1_c)),
        .pop_i   (pop1),
        .head_o  (head1),
        .empty_o (empty1),
        .full_o  (full1),
        .drop_o  (drop1)
    );

    // start: a new burst is waiting at the head; more: the current burst continues.
    assign start0 = !empty0 &&  head0[WORD_W-1];
    assign more0  = !empty0 && !head0[WORD_W-1];
    assign start1 = !empty1 &&  head1[WORD_W-1];
    assign more1  = !empty1 && !head1[WORD_W-1];

    always_comb begin
        state_d = state_q;
        pop0    = 1'b0;
        pop1    = 1'b0;
        case (state_q)
            RESET:       state_d = INICIAL;
            INICIAL:     if (start0) begin pop0 = 1'b1; state_d = TRANS_0; end
            TRANS_0:     if (more0) pop0 = 1'b1; else state_d = W_LST_DATA0;
            W_LST_DATA0: if (start1) begin pop1 = 1'b1; state_d = TRANS_1; end
            TRANS_1:     if (more1) pop1 = 1'b1; else state_d = W_LST_DATA1;
            W_LST_DATA1: if (start0) begin pop0 = 1'b1; state_d = TRANS_0; end
            default:     state_d = RESET;
        endcase
    end

    always_ff @(posedge clk2f) begin
        if (reset) begin
            state_q     <= RESET;
            prev_v0_q   <= 1'b0;
            prev_v1_q   <= 1'b0;
            data_out_c  <= '0;
            valid_out_c <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_v0_q   <= valid_in_0_c;
            prev_v1_q   <= valid_in_1_c;
            valid_out_c <= pop0 || pop1;
            data_out_c  <= pop0 ? head0[DATA_W-1:0] : pop1 ? head1[DATA_W-1:0] : '0;
        end
    end

`ifdef MUX_ALT_OVF_EN
    logic ovf_0_q, ovf_1_q;

    always_ff @(posedge clk2f) begin
        if (reset) begin
            ovf_0_q <= 1'b0;
            ovf_1_q <= 1'b0;
        end else begin
            ovf_0_q <= ovf_0_q || drop0;
            ovf_1_q <= ovf_1_q || drop1;
        end
    end

    assign ovf_0 = ovf_0_q;
    assign ovf_1 = ovf_1_q;
`else
    logic unused_drop;

    assign unused_drop = &{1'b0, drop0, drop1};
    assign ovf_0       = 1'b0;
    assign ovf_1       = 1'b0;
`endif

    logic unused_full;

    assign unused_full = &{1'b0, full0, full1};

endmodule

// File: tb/tb_mux_alt.sv
// tb_mux_alt: self-checking bench for mux_alt (vector table, directed sequences, random vs. queue model).
module tb_mux_alt;

`ifdef MUX_ALT_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic       clk2f = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] d0 = 8'h00, d1 = 8'h00;
    logic       v0 = 1'b0, v1 = 1'b0;
    logic [7:0] data_out_c;
    logic       valid_out_c, ovf_0, ovf_1;

    int checks = 0;
    int failures = 0;

    mux_alt dut (
        .clk2f        (clk2f),
        .reset        (reset),
        .data_in_0_c  (d0),
        .valid_in_0_c (v0),
        .data_in_1_c  (d1),
        .valid_in_1_c (v1),
        .data_out_c   (data_out_c),
        .valid_out_c  (valid_out_c),
        .ovf_0        (ovf_0),
        .ovf_1        (ovf_1)
    );

    always #5 clk2f = ~clk2f;

    // Reference model: per-lane word queues plus "which lane owns the output" and "inside a burst".
    logic [8:0] mq0[$], mq1[$];
    bit         m_lane = 1'b0, m_busy = 1'b0, m_armed = 1'b0;
    bit         m_p0 = 1'b0, m_p1 = 1'b0, m_o0 = 1'b0, m_o1 = 1'b0;
    bit         m_valid = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic [7:0] obs[$];

    task automatic model_edge(input bit r, input bit a0, input logic [7:0] x0,
                              input bit a1, input logic [7:0] x1);
        m_valid = 1'b0;
        m_data  = 8'h00;
        if (r) begin
            mq0.delete();
            mq1.delete();
            m_lane = 1'b0; m_busy = 1'b0; m_armed = 1'b0;
            m_p0 = 1'b0; m_p1 = 1'b0; m_o0 = 1'b0; m_o1 = 1'b0;
            return;
        end
        if (!m_armed) begin
            m_armed = 1'b1;
        end else if (m_lane == 1'b0) begin
            if (mq0.size() > 0 && mq0[0][8] != m_busy) begin
                m_valid = 1'b1; m_data = mq0[0][7:0]; void'(mq0.pop_front()); m_busy = 1'b1;
            end else if (m_busy) begin
                m_busy = 1'b0; m_lane = 1'b1;
            end
        end else begin
            if (mq1.size() > 0 && mq1[0][8] != m_busy) begin
                m_valid = 1'b1; m_data = mq1[0][7:0]; void'(mq1.pop_front()); m_busy = 1'b1;
            end else if (m_busy) begin
                m_busy = 1'b0; m_lane = 1'b0;
            end
        end
        if (a0) begin
            if (mq0.size() < 4) mq0.push_back({!m_p0, x0});
            else m_o0 = m_o0 | OVF_EN;
        end
        if (a1) begin
            if (mq1.size() < 4) mq1.push_back({!m_p1, x1});
            else m_o1 = m_o1 | OVF_EN;
        end
        m_p0 = a0;
        m_p1 = a1;
    endtask

    task automatic step(input bit r, input bit a0, input logic [7:0] x0,
                        input bit a1, input logic [7:0] x1);
        reset = r; v0 = a0; d0 = x0; v1 = a1; d1 = x1;
        @(posedge clk2f);
        model_edge(r, a0, x0, a1, x1);
        #1;
        checks++;
        if ({valid_out_c, data_out_c} !== {m_valid, m_data}) begin
            failures++;
            $display("FAIL out t=%0t: got v=%b d=%h, expected v=%b d=%h",
                     $time, valid_out_c, data_out_c, m_valid, m_data);
        end
        checks++;
        if ({ovf_0, ovf_1} !== {m_o0, m_o1}) begin
            failures++;
            $display("FAIL ovf t=%0t: got %b%b, expected %b%b", $time, ovf_0, ovf_1, m_o0, m_o1);
        end
        if (r) obs.delete();
        else if (valid_out_c === 1'b1) obs.push_back(data_out_c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic check_seq(input string name, input logic [7:0] exp[$]);
        checks++;
        if (obs.size() != exp.size()) begin
            failures++;
            $display("FAIL %s length: got %0d words, expected %0d", name, obs.size(), exp.size());
        end else begin
            foreach (exp[i]) begin
                checks++;
                if (obs[i] !== exp[i]) begin
                    failures++;
                    $display("FAIL %s word %0d: got %h, expected %h", name, i, obs[i], exp[i]);
                end
            end
        end
    endtask

    typedef struct {
        bit         r;
        bit         a0;
        logic [7:0] x0;
        bit         a1;
        logic [7:0] x1;
        bit         ev;
        logic [7:0] ed;
    } vec_t;

    vec_t       tbl[13];
    logic [7:0] e[$];
    bit         rv0, rv1;

    initial begin
        // Lane 0 burst A0..A3, gap, lane 1 burst B0..B2, with hand-derived outputs.
        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
        tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
        tbl[2]  = '{1'b0, 1'b1, 8'hA0, 1'b0, 8'h00, 1'b0, 8'h00};
        tbl[3]  = '{1'b0, 1'b1, 8'hA1, 1'b0, 8'h00, 1'b1, 8'hA0};
        tbl[4]  = '{1'b0, 1'b1, 8'hA2, 1'b0, 8'h00, 1'b1, 8'hA1};
        tbl[5]  = '{1'b0, 1'b1, 8'hA3, 1'b0, 8'h00, 1'b1, 8'hA2};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA3};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hB0, 1'b0, 8'h00};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hB1, 1'b1, 8'hB0};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hB2, 1'b1, 8'hB1};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hB2};
        tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
        #2;
        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].a0, tbl[i].x0, tbl[i].a1, tbl[i].x1);
            checks++;
            if ({valid_out_c, data_out_c} !== {tbl[i].ev, tbl[i].ed}) begin
                failures++;
                $display("FAIL vec%0d: got v=%b d=%h, expected v=%b d=%h",
                         i, valid_out_c, data_out_c, tbl[i].ev, tbl[i].ed);
            end
        end
        e = {8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2};
        check_seq("burst_alt", e);

        // Lane 1 arrives first but must wait for the first lane 0 burst.
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        idle(1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 8'h10);
        step(1'b0, 1'b0, 8'h00, 1'b1, 8'h11);
        step(1'b0, 1'b0, 8'h00, 1'b1, 8'h12);
        idle(2);
        step(1'b0, 1'b1, 8'h20, 1'b0, 8'h00);
        idle(10);
        e = {8'h20, 8'h10, 8'h11, 8'h12};
        check_seq("lane0_first", e);

        // Two lane 0 bursts separated by a gap are separated by a lane 1 burst.
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        idle(1);
        step(1'b0, 1'b1, 8'h01, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h02, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00, 1'b1, 8'h55);
        step(1'b0, 1'b1, 8'h03, 1'b0, 8'h00);
        idle(8);
        e = {8'h01, 8'h02, 8'h55, 8'h03};
        check_seq("back_to_back", e);

        // Lane 1 overfills while lane 0 owns the output: words 5 and 6 are lost.
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        idle(1);
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b1, 8'(i + 1), i < 6, 8'(8'h31 + i));
        idle(12);
        e = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
             8'h31, 8'h32, 8'h33, 8'h34};
        check_seq("overflow", e);
        checks++;
        if (ovf_1 !== OVF_EN || ovf_0 !== 1'b0) begin
            failures++;
            $display("FAIL ovf_flags: got ovf_0=%b ovf_1=%b, expected ovf_0=0 ovf_1=%b", ovf_0, ovf_1, OVF_EN);
        end

        // Reset in the middle of a lane 0 burst discards everything buffered.
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        idle(1);
        step(1'b0, 1'b1, 8'hA0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'hA1, 1'b1, 8'h66);
        step(1'b0, 1'b1, 8'hA2, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'hA3, 1'b0, 8'h00);
        checks++;
        if (valid_out_c !== 1'b0 || data_out_c !== 8'h00 || ovf_0 !== 1'b0 || ovf_1 !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: got v=%b d=%h ovf=%b%b, expected all 0",
                     valid_out_c, data_out_c, ovf_0, ovf_1);
        end
        step(1'b0, 1'b1, 8'hA4, 1'b1, 8'h77);
        step(1'b0, 1'b1, 8'hA5, 1'b0, 8'h00);
        idle(8);
        e = {8'hA4, 8'hA5, 8'h77};
        check_seq("after_reset", e);

        // Random bursts on both lanes with rare resets, checked every cycle against the model.
        rv0 = 1'b0;
        rv1 = 1'b0;
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) rv0 = !rv0;
            if ($urandom_range(0, 3) == 0) rv1 = !rv1;
            step($urandom_range(0, 299) == 0, rv0, 8'($urandom), rv1, 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
